// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_param
// Purpose  : Parametrised serial bit-pattern detector. One bit is sampled per
//            clock when in_valid is high, and a registered single-cycle pulse
//            is produced for each completed PATTERN (MSB received first).
//            Overlapping or non-overlapping matching can be selected, and a
//            saturating counter records the number of matches.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous active-high reset
//            in_valid   - qualifies in; a bit is sampled only when high
//            in         - serial data bit
//            clr_cnt    - synchronous clear of match_cnt
//            out        - registered match pulse
//            match_cnt  - saturating match counter
//            fill       - number of valid bits held in history (0..PAT_LEN)
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in,
    input  logic                           clr_cnt,
    output logic                           out,
    output logic [CNT_W-1:0]               match_cnt,
    output logic [$clog2(PAT_LEN+1)-1:0]   fill
);

    localparam int                    c_fill_w    = $clog2(PAT_LEN + 1);
    localparam logic [c_fill_w-1:0]   c_fill_full = c_fill_w'(PAT_LEN);
    localparam logic [c_fill_w-1:0]   c_fill_one  = c_fill_w'(1);
    localparam logic [CNT_W-1:0]      c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      c_cnt_one   = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PAT_LEN-1:0]  r_hist;
    logic [c_fill_w-1:0] r_fill;
    logic                r_out;
    logic [CNT_W-1:0]    r_cnt;

    // ------------------------------------------------------------------------
    // Next-state terms for an accept cycle
    // ------------------------------------------------------------------------
    logic [PAT_LEN-1:0]  w_hist_nxt;
    logic [c_fill_w-1:0] w_fill_nxt;
    logic                w_match;
    logic                w_cnt_sat;

    always_comb begin
        w_hist_nxt = {r_hist[PAT_LEN-2:0], in};
        // fill saturates at PAT_LEN: once full, history is a sliding window
        w_fill_nxt = (r_fill == c_fill_full) ? r_fill : (r_fill + c_fill_one);
        // A match needs both the right contents and a fully-populated window,
        // so stale bits left over after a reset or restart never match.
        w_match    = in_valid && (w_hist_nxt == PATTERN) && (w_fill_nxt == c_fill_full);
        w_cnt_sat  = (r_cnt == c_cnt_max);
    end

    // ------------------------------------------------------------------------
    // History and fill level
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (in_valid) begin
            r_hist <= w_hist_nxt;
            // Non-overlapping mode only needs fill cleared: the old history
            // bits are shifted out before fill can reach PAT_LEN again.
            if (w_match && !OVERLAP) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Match pulse: registered, so there is no combinational path in -> out
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_match;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating match counter; clear has priority over a coincident match
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_match && !w_cnt_sat) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign out       = r_out;
    assign match_cnt = r_cnt;
    assign fill      = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_param
// Purpose  : Directed and model-based self-checking bench for seq_detect_param.
//            Five instances share one stimulus stream:
//              a : 1101, overlapping,     CNT_W=8
//              b : 1101, non-overlapping, CNT_W=8
//              c : 1101, overlapping,     CNT_W=2
//              d : A5 (8 bits), overlapping, CNT_W=8
//              e : 1111, overlapping,     CNT_W=8
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    logic clk;
    logic rst;
    logic in_valid;
    logic din;
    logic clr_cnt;

    logic       out_a, out_b, out_c, out_d, out_e;
    logic [7:0] cnt_a, cnt_b, cnt_d, cnt_e;
    logic [1:0] cnt_c;
    logic [2:0] fill_a, fill_b, fill_c, fill_e;
    logic [3:0] fill_d;

    int checks = 0;
    int passes = 0;

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .clr_cnt(clr_cnt),
        .out(out_a), .match_cnt(cnt_a), .fill(fill_a));

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .clr_cnt(clr_cnt),
        .out(out_b), .match_cnt(cnt_b), .fill(fill_b));

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .clr_cnt(clr_cnt),
        .out(out_c), .match_cnt(cnt_c), .fill(fill_c));

    seq_detect_param #(.PAT_LEN(8), .PATTERN(8'hA5), .OVERLAP(1'b1), .CNT_W(8)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .clr_cnt(clr_cnt),
        .out(out_d), .match_cnt(cnt_d), .fill(fill_d));

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .clr_cnt(clr_cnt),
        .out(out_e), .match_cnt(cnt_e), .fill(fill_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, take the edge, settle 1 time unit after it.
    task automatic step(input logic v, input logic b);
        in_valid = v;
        din      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        din      = 1'b0;
        clr_cnt  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        // Pre-load history and a pulse, then reset while in_valid stays high.
        step(1, 1); step(1, 1); step(1, 0); step(1, 1);
        rst = 1'b1;
        step(1, 1);
        step(1, 1);
        checks++; if (out_a !== 1'b0) $display("FAIL reset_out: got %0b expected 0", out_a); else passes++;
        checks++; if (fill_a !== 3'd0) $display("FAIL reset_fill: got %0d expected 0", fill_a); else passes++;
        checks++; if (cnt_a !== 8'd0) $display("FAIL reset_cnt: got %0d expected 0", cnt_a); else passes++;
        checks++; if (fill_d !== 4'd0) $display("FAIL reset_fill_d: got %0d expected 0", fill_d); else passes++;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] exp;
        bits = 7'b1101101;
        exp  = 7'b0001001;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(1, bits[i]);
            checks++;
            if (out_a !== exp[i]) $display("FAIL overlap_out bit%0d: got %0b expected %0b", 7 - i, out_a, exp[i]);
            else passes++;
        end
        checks++; if (cnt_a !== 8'd2) $display("FAIL overlap_cnt: got %0d expected 2", cnt_a); else passes++;
        checks++; if (fill_a !== 3'd4) $display("FAIL overlap_fill: got %0d expected 4", fill_a); else passes++;
        step(0, 0);
        checks++; if (out_a !== 1'b0) $display("FAIL overlap_idle_out: got %0b expected 0", out_a); else passes++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_non_overlap();
        logic [6:0] bits;
        logic [6:0] exp;
        bits = 7'b1101101;
        exp  = 7'b0001000;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(1, bits[i]);
            checks++;
            if (out_b !== exp[i]) $display("FAIL nonovl_out bit%0d: got %0b expected %0b", 7 - i, out_b, exp[i]);
            else passes++;
        end
        checks++; if (cnt_b !== 8'd1) $display("FAIL nonovl_cnt: got %0d expected 1", cnt_b); else passes++;
        checks++; if (fill_b !== 3'd3) $display("FAIL nonovl_fill: got %0d expected 3", fill_b); else passes++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_gap();
        do_reset();
        step(1, 1); step(1, 1); step(1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1);
            checks++;
            if (out_a !== 1'b0 || fill_a !== 3'd3)
                $display("FAIL gap_hold cyc%0d: got out=%0b fill=%0d expected out=0 fill=3", i, out_a, fill_a);
            else passes++;
        end
        step(1, 1);
        checks++; if (out_a !== 1'b1) $display("FAIL gap_match: got %0b expected 1", out_a); else passes++;
        step(0, 0);
        checks++; if (out_a !== 1'b0) $display("FAIL gap_pulse_end: got %0b expected 0", out_a); else passes++;
        checks++; if (cnt_a !== 8'd1) $display("FAIL gap_cnt: got %0d expected 1", cnt_a); else passes++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        do_reset();
        step(1, 1); step(1, 1); step(1, 0);
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
        step(1, 1);
        checks++; if (out_a !== 1'b0) $display("FAIL rstmid_out: got %0b expected 0", out_a); else passes++;
        checks++; if (fill_a !== 3'd1) $display("FAIL rstmid_fill: got %0d expected 1", fill_a); else passes++;
        step(1, 1);
        step(1, 0);
        checks++; if (out_a !== 1'b0) $display("FAIL rstmid_early: got %0b expected 0", out_a); else passes++;
        step(1, 1);
        checks++; if (out_a !== 1'b1) $display("FAIL rstmid_match: got %0b expected 1", out_a); else passes++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_saturate();
        logic [15:0] bits;
        bits = 16'b1101101101101101;   // five overlapping matches
        do_reset();
        for (int i = 15; i >= 0; i--) step(1, bits[i]);
        checks++; if (cnt_c !== 2'd3) $display("FAIL sat_cnt: got %0d expected 3", cnt_c); else passes++;
        checks++; if (cnt_a !== 8'd5) $display("FAIL sat_cnt_wide: got %0d expected 5", cnt_a); else passes++;
        // History ends ...1101; feed 1,0 then 1 with clr_cnt on the matching edge.
        step(1, 1);
        step(1, 0);
        clr_cnt = 1'b1;
        step(1, 1);
        clr_cnt = 1'b0;
        checks++; if (out_c !== 1'b1) $display("FAIL clr_out: got %0b expected 1", out_c); else passes++;
        checks++; if (cnt_c !== 2'd0) $display("FAIL clr_cnt: got %0d expected 0", cnt_c); else passes++;
        checks++; if (fill_c !== 3'd4) $display("FAIL clr_fill: got %0d expected 4", fill_c); else passes++;
        step(1, 1);
        checks++; if (cnt_c !== 2'd0 || out_c !== 1'b0)
            $display("FAIL clr_after: got cnt=%0d out=%0b expected cnt=0 out=0", cnt_c, out_c);
        else passes++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [5:0] exp;
        exp = 6'b000111;
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            step(1, 1);
            checks++;
            if (out_e !== exp[i]) $display("FAIL b2b_out bit%0d: got %0b expected %0b", 6 - i, out_e, exp[i]);
            else passes++;
        end
        checks++; if (cnt_e !== 8'd3) $display("FAIL b2b_cnt: got %0d expected 3", cnt_e); else passes++;
        step(0, 1);
        checks++; if (out_e !== 1'b0) $display("FAIL b2b_gap: got %0b expected 0", out_e); else passes++;
        step(1, 1);
        checks++; if (out_e !== 1'b1) $display("FAIL b2b_resume: got %0b expected 1", out_e); else passes++;
    endtask

    // ------------------------------------------------------------------------
    // Reference: keep the last accepted bits in a queue; a match is the most
    // recent eight accepted bits reading A5 (oldest first).
    task automatic test_random();
        bit         q[$];
        logic [7:0] seed_bits;
        logic [7:0] win;
        logic       v, b, exp_out;
        int         exp_cnt;
        int         bad;
        seed_bits = 8'hA5;
        exp_cnt   = 0;
        bad       = 0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if (i < 8) begin
                v = 1'b1;
                b = seed_bits[7 - i];
            end else begin
                v = ($urandom_range(0, 3) != 0);
                b = 1'($urandom_range(0, 1));
            end
            exp_out = 1'b0;
            if (v) begin
                q.push_back(b);
                if (q.size() > 8) void'(q.pop_front());
                if (q.size() == 8) begin
                    for (int k = 0; k < 8; k++) win[7 - k] = q[k];
                    if (win == 8'hA5) begin
                        exp_out = 1'b1;
                        if (exp_cnt < 255) exp_cnt++;
                    end
                end
            end
            step(v, b);
            checks++;
            if (out_d !== exp_out || cnt_d !== 8'(exp_cnt) || fill_d !== 4'(q.size())) begin
                bad++;
                if (bad <= 10)
                    $display("FAIL rand_step%0d: got out=%0b cnt=%0d fill=%0d expected out=%0b cnt=%0d fill=%0d",
                             i, out_d, cnt_d, fill_d, exp_out, exp_cnt, q.size());
            end else passes++;
        end
        checks++; if (cnt_d == 8'd0) $display("FAIL rand_any_match: got cnt=%0d expected nonzero", cnt_d); else passes++;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        din      = 1'b0;
        clr_cnt  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gap();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
